adc_frame_streamer: RTL and testbench
=====================================

// Module: adc_frame_streamer
// PURPOSE
//  Parametrised capture-and-stream engine for the ADC -> FFT path. On an external trigger it captures
//  2**ADDR_W samples from a selectable ADC channel into internal dual-port RAM, one sample per rising
//  edge of an external sample strobe. It then streams the frame to the FFT core over Avalon-ST with
//  sop/eop and backpressure, and waits for the FFT output sop. Supports single-shot and continuous re-arm.
// PARAMETERS
//  DATA_W        14  ADC sample width in bits
//  NUM_CH         2  ADC channels on adc_data; CH_W = max(1, clog2(NUM_CH))
//  ADDR_W        13  log2 of frame length (default 8192 points)
//  OFFSET_BINARY  1  1: invert the sample MSB on write (offset-binary -> two's complement); 0: pass through
// PORTS
//  clk          in   1                system clock, 65 MHz ADC domain
//  reset_n      in   1                async active-low reset
//  adc_data     in   NUM_CH*DATA_W    ADC words; channel k at [k*DATA_W +: DATA_W]; synchronous to clk
//  ext_smp_clk  in   1                async external sample strobe; 2-FF synchronised internally
//  ext_trig     in   1                async trigger; 2-FF synchronised internally; rising edge only
//  arm          in   1                1-cycle pulse; IDLE -> ARMED
//  continuous   in   1                sampled at frame end; 1 = re-arm automatically
//  ch_sel       in   CH_W             channel select, latched on arm; values >= NUM_CH select channel 0
//  src_ready    in   1                FFT sink_ready
//  src_valid    out  1                FFT sink_valid
//  src_data     out  DATA_W           FFT sink_real
//  src_sop      out  1                FFT sink_sop
//  src_eop      out  1                FFT sink_eop
//  fft_sop      in   1                FFT source_sop; marks the start of the result frame
//  busy         out  1                state != IDLE
//  state_o      out  3                encoded state: IDLE=0 ARMED=1 CAPTURE=2 STREAM=3 WAIT_FFT=4
//  frame_cnt    out  16               completed frames; wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state IDLE; all counters, sync flops and outputs 0; RAM contents undefined.
//  Edge detect:
//   - smp_rise / trig_rise = synchronised level high AND previous synchronised level low.
//   - Pin edge -> detect pulse: 3 clk latency.
//  IDLE:
//   - arm=1 -> ARMED; latch ch_sel.
//  ARMED:
//   - trig_rise -> CAPTURE; wr_addr=0.
//   - arm is ignored in every state except IDLE.
//  CAPTURE:
//   - Each smp_rise writes the latched channel's adc_data (MSB inverted when OFFSET_BINARY) to
//     RAM[wr_addr], then wr_addr+1.
//   - Write of address 2**ADDR_W-1 -> STREAM on the next cycle.
//   - Triggers during capture are ignored.
//   - Sample strobes outside CAPTURE are ignored.
//  STREAM (Avalon-ST, ready latency 0):
//   - Word i = RAM[i], i = 0..2**ADDR_W-1.
//   - src_valid is asserted only when src_data holds word i; a beat transfers when src_valid & src_ready.
//   - While src_valid & !src_ready: src_data, src_sop and src_eop are held stable and src_valid stays 1.
//   - src_sop=1 only on word 0; src_eop=1 only on the last word.
//   - RAM read latency is 1 cycle. Prefetch or skid so that with src_ready held high, one beat transfers
//     every cycle after the first src_valid.
//   - The first src_valid occurs <= 2 cycles after entering STREAM.
//   - Accepted last word -> WAIT_FFT; src_valid, src_sop and src_eop return to 0 in the same cycle.
//  WAIT_FFT:
//   - fft_sop=1 -> frame_cnt+1, then ARMED if continuous=1, else IDLE.
//   - fft_sop seen in any other state is ignored.
//  Outputs: all registered; no combinational path from inputs to outputs.
// TESTING
//  1. Reset: reset_n=0 mid-STREAM -> state_o=0, src_valid=0, frame_cnt=0 within the same cycle.
//  2. ADDR_W=4, NUM_CH=2, ch_sel=1, OFFSET_BINARY=1; arm, trig, 16 strobes with ch1=0x2000+i
//     -> stream data 0x0000+i, i=0..15; sop on i=0, eop on i=15; state IDLE after fft_sop; frame_cnt=1.
//  3. Backpressure: src_ready toggling 1,0,0,1 during STREAM -> no word dropped or duplicated; data and
//     flags stable while stalled.
//  4. continuous=1, two triggers -> two full frames, frame_cnt=2, state_o=1 after the second fft_sop.
//  5. ext_trig pulses and arm during CAPTURE, and strobes during STREAM -> no effect on the 16 captured
//     words or the state sequence.
//  6. Strobe held high for 10 clk -> exactly one write; src_ready=1 throughout -> 16 beats on consecutive
//     cycles.

Source files
------------

// File: rtl/adc_frame_streamer.sv
// Trigger-armed ADC frame capture into on-chip RAM, then Avalon-ST streaming of the frame to the FFT.
// Read path uses a registered RAM read plus one skid entry so a beat can transfer every cycle.
module adc_frame_streamer #(
  parameter int DATA_W        = 14,
  parameter int NUM_CH        = 2,
  parameter int ADDR_W        = 13,
  parameter int OFFSET_BINARY = 1,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic                     ext_smp_clk,
  input  logic                     ext_trig,
  input  logic                     arm,
  input  logic                     continuous,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic                     src_ready,
  output logic                     src_valid,
  output logic [DATA_W-1:0]        src_data,
  output logic                     src_sop,
  output logic                     src_eop,
  input  logic                     fft_sop,
  output logic                     busy,
  output logic [2:0]               state_o,
  output logic [15:0]              frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_CAPTURE  = 3'd2,
    S_STREAM   = 3'd3,
    S_WAIT_FFT = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] MSB_MASK  = (OFFSET_BINARY != 0) ?
                                            {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]     rd_addr_q, rd_addr_d;
  logic                rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
  logic                skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [ADDR_W-1:0]   skid_idx_q, skid_idx_d;
  logic                out_vld_q, out_vld_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                busy_q, busy_d;

  logic smp_meta_q, smp_sync_q, smp_prev_q, smp_rise_q;
  logic trig_meta_q, trig_sync_q, trig_prev_q, trig_rise_q;

  logic                wr_en_s, rd_en_s, pop_s;
  logic [1:0]          occ_s;
  logic [DATA_W-1:0]   sample_s;
  logic [DATA_W-1:0]   ch_word_s [NUM_CH];
  logic [DATA_W-1:0]   mem [2**ADDR_W];
  logic [DATA_W-1:0]   rd_data_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_word_s[k] = adc_data[k*DATA_W +: DATA_W];
  end
  assign sample_s = ch_word_s[ch_q] ^ MSB_MASK;

  // Two-flop synchronisers followed by a registered rising-edge detect (3 clk pin-to-pulse).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_meta_q  <= 1'b0;
      smp_sync_q  <= 1'b0;
      smp_prev_q  <= 1'b0;
      smp_rise_q  <= 1'b0;
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
      trig_prev_q <= 1'b0;
      trig_rise_q <= 1'b0;
    end else begin
      smp_meta_q  <= ext_smp_clk;
      smp_sync_q  <= smp_meta_q;
      smp_prev_q  <= smp_sync_q;
      smp_rise_q  <= smp_sync_q & ~smp_prev_q;
      trig_meta_q <= ext_trig;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
      trig_rise_q <= trig_sync_q & ~trig_prev_q;
    end
  end

  // Frame RAM: contents and read register are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_addr_q] <= sample_s;
    end
    if (rd_en_s) begin
      rd_data_q <= mem[rd_addr_q[ADDR_W-1:0]];
    end
  end

  // Next-state, capture addressing and the output/skid/read-in-flight streaming pipeline.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    rd_vld_d    = 1'b0;
    rd_idx_d    = rd_idx_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_idx_d  = skid_idx_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    frame_cnt_d = frame_cnt_q;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    pop_s       = out_vld_q & src_ready;
    occ_s       = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q};

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_ARMED;
          ch_d    = (int'(ch_sel) < NUM_CH) ? ch_sel : {CH_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (trig_rise_q) begin
          state_d   = S_CAPTURE;
          wr_addr_d = {ADDR_W{1'b0}};
        end else begin
          state_d = S_ARMED;
        end
      end
      S_CAPTURE: begin
        if (smp_rise_q) begin
          wr_en_s = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            state_d    = S_STREAM;
            wr_addr_d  = {ADDR_W{1'b0}};
            rd_addr_d  = {(ADDR_W+1){1'b0}};
            skid_vld_d = 1'b0;
            out_vld_d  = 1'b0;
            out_sop_d  = 1'b0;
            out_eop_d  = 1'b0;
          end else begin
            wr_addr_d = wr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_STREAM: begin
        // Issue a read only if output + skid can absorb everything in flight.
        rd_en_s   = ~rd_addr_q[ADDR_W] & ((occ_s - {1'b0, pop_s}) <= 2'd1);
        rd_vld_d  = rd_en_s;
        rd_idx_d  = rd_addr_q[ADDR_W-1:0];
        rd_addr_d = rd_addr_q + {{ADDR_W{1'b0}}, rd_en_s};
        if (!out_vld_q || pop_s) begin
          if (skid_vld_q) begin
            out_vld_d   = 1'b1;
            out_data_d  = skid_data_q;
            out_sop_d   = (skid_idx_q == {ADDR_W{1'b0}});
            out_eop_d   = (skid_idx_q == LAST_ADDR);
            skid_vld_d  = rd_vld_q;
            skid_data_d = rd_data_q;
            skid_idx_d  = rd_idx_q;
          end else if (rd_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = rd_data_q;
            out_sop_d  = (rd_idx_q == {ADDR_W{1'b0}});
            out_eop_d  = (rd_idx_q == LAST_ADDR);
          end else begin
            out_vld_d = 1'b0;
            out_sop_d = 1'b0;
            out_eop_d = 1'b0;
          end
        end else if (rd_vld_q) begin
          skid_vld_d  = 1'b1;
          skid_data_d = rd_data_q;
          skid_idx_d  = rd_idx_q;
        end else begin
          skid_vld_d = skid_vld_q;
        end
        if (pop_s && out_eop_q) begin
          state_d    = S_WAIT_FFT;
          out_vld_d  = 1'b0;
          out_sop_d  = 1'b0;
          out_eop_d  = 1'b0;
          skid_vld_d = 1'b0;
          rd_vld_d   = 1'b0;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_WAIT_FFT: begin
        if (fft_sop) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = continuous ? S_ARMED : S_IDLE;
        end else begin
          state_d = S_WAIT_FFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ch_q        <= {CH_W{1'b0}};
      wr_addr_q   <= {ADDR_W{1'b0}};
      rd_addr_q   <= {(ADDR_W+1){1'b0}};
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= {ADDR_W{1'b0}};
      skid_vld_q  <= 1'b0;
      skid_data_q <= {DATA_W{1'b0}};
      skid_idx_q  <= {ADDR_W{1'b0}};
      out_vld_q   <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_idx_q    <= rd_idx_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_idx_q  <= skid_idx_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign src_valid = out_vld_q;
  assign src_data  = out_data_q;
  assign src_sop   = out_sop_q;
  assign src_eop   = out_eop_q;
  assign busy      = busy_q;
  assign state_o   = state_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_frame_streamer.sv
// Scoreboard bench for adc_frame_streamer with a 16-point frame: expected beats are queued
// as samples are strobed in and compared as the DUT streams them out.
module tb_adc_frame_streamer;
  localparam int DW  = 14;
  localparam int NCH = 2;
  localparam int AW  = 4;
  localparam int NW  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH*DW-1:0] adc_data = '0;
  logic              ext_smp_clk = 1'b0;
  logic              ext_trig = 1'b0;
  logic              arm = 1'b0;
  logic              continuous = 1'b0;
  logic [0:0]        ch_sel = 1'b0;
  logic              src_ready = 1'b0;
  logic              src_valid;
  logic [DW-1:0]     src_data;
  logic              src_sop;
  logic              src_eop;
  logic              fft_sop = 1'b0;
  logic              busy;
  logic [2:0]        state_o;
  logic [15:0]       frame_cnt;

  adc_frame_streamer #(.DATA_W(DW), .NUM_CH(NCH), .ADDR_W(AW), .OFFSET_BINARY(1)) dut (
    .clk(clk), .reset_n(reset_n), .adc_data(adc_data), .ext_smp_clk(ext_smp_clk),
    .ext_trig(ext_trig), .arm(arm), .continuous(continuous), .ch_sel(ch_sel),
    .src_ready(src_ready), .src_valid(src_valid), .src_data(src_data), .src_sop(src_sop),
    .src_eop(src_eop), .fft_sop(fft_sop), .busy(busy), .state_o(state_o), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int ready_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int k;
    k = 0;
    while (state_o !== s && k < budget) begin
      tick(1);
      k++;
    end
    check("state_wait", {29'd0, state_o}, {29'd0, s});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // src_ready pattern: 0 = always ready, 1 = repeating 1,0,0,1, 2 = never ready
  initial begin
    int p;
    p = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: src_ready = 1'b1;
        1: src_ready = (p % 4 == 0) || (p % 4 == 3);
        default: src_ready = 1'b0;
      endcase
      p++;
    end
  end

  // Output monitor: compare each accepted beat, and held words while stalled.
  always @(negedge clk) begin
    if (reset_n) begin
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", {18'd0, src_data}, {18'd0, mon_e[13:0]});
          check("beat_sop", {31'd0, src_sop}, {31'd0, mon_e[15]});
          check("beat_eop", {31'd0, src_eop}, {31'd0, mon_e[14]});
        end
        if (beat_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        beat_cnt++;
      end else if (src_valid && exp_q.size() > 0) begin
        check("stall_data", {18'd0, src_data}, {18'd0, exp_q[0][13:0]});
        check("stall_sop", {31'd0, src_sop}, {31'd0, exp_q[0][15]});
        check("stall_eop", {31'd0, src_eop}, {31'd0, exp_q[0][14]});
      end
    end
  end

  task automatic capture_frame(input int ch, input bit ramp, input int hold, input bit disturb);
    for (int i = 0; i < NW; i++) begin
      logic [DW-1:0] v0, v1, sel;
      v0 = DW'($urandom);
      v1 = ramp ? (14'h2000 + DW'(i)) : DW'($urandom);
      adc_data = {v1, v0};
      sel = (ch == 1) ? v1 : v0;
      exp_q.push_back({(i == 0), (i == NW-1), sel ^ 14'h2000});
      ext_smp_clk = 1'b1;
      tick(hold);
      ext_smp_clk = 1'b0;
      tick(4);
      if (disturb && i == 5) begin
        ext_trig = 1'b1;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        tick(3);
        ext_trig = 1'b0;
        tick(4);
        check("cap_state", {29'd0, state_o}, 32'd2);
      end
    end
  endtask

  task automatic do_frame(input int ch, input bit ramp, input int hold, input bit disturb,
                          input bit smp_in_stream, input logic [2:0] end_state,
                          input logic [15:0] end_cnt);
    beat_cnt = 0;
    ext_trig = 1'b1;
    tick(3);
    ext_trig = 1'b0;
    wait_state(3'd2, 20);
    capture_frame(ch, ramp, hold, disturb);
    if (smp_in_stream) begin
      check("in_stream", {29'd0, state_o}, 32'd3);
      repeat (3) begin
        ext_smp_clk = 1'b1;
        tick(2);
        ext_smp_clk = 1'b0;
        tick(2);
      end
    end
    wait_state(3'd4, 300);
    check("q_empty", exp_q.size(), 32'd0);
    check("beats", beat_cnt, NW);
    tick(2);
    check("wait_hold", {29'd0, state_o}, 32'd4);
    fft_sop = 1'b1;
    tick(1);
    fft_sop = 1'b0;
    tick(2);
    check("end_state", {29'd0, state_o}, {29'd0, end_state});
    check("frame_cnt", {16'd0, frame_cnt}, {16'd0, end_cnt});
  endtask

  initial begin
    int k;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("rst_state", {29'd0, state_o}, 32'd0);
    check("rst_valid", {31'd0, src_valid}, 32'd0);
    check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Frame 1: ch1 ramp, strobe held 10 clk, always ready.
    ch_sel = 1'b1;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(2);
    check("armed", {29'd0, state_o}, 32'd1);
    check("busy", {31'd0, busy}, 32'd1);
    do_frame(1, 1'b1, 10, 1'b0, 1'b0, 3'd0, 16'd1);
    check("consecutive", last_cyc - first_cyc, NW - 1);

    // Frame 2: ch0 random, backpressure, disturbances during capture and stream.
    ch_sel = 1'b0;
    ready_mode = 1;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(2);
    fft_sop = 1'b1;
    tick(1);
    fft_sop = 1'b0;
    tick(2);
    check("armed_fft_ign", {29'd0, state_o}, 32'd1);
    check("armed_fft_cnt", {16'd0, frame_cnt}, 32'd1);
    do_frame(0, 1'b0, 4, 1'b1, 1'b1, 3'd0, 16'd2);

    // Frames 3-4: continuous re-arm.
    continuous = 1'b1;
    ready_mode = 0;
    ch_sel = 1'b1;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(2);
    do_frame(1, 1'b0, 5, 1'b0, 1'b0, 3'd1, 16'd3);
    ready_mode = 1;
    do_frame(1, 1'b0, 6, 1'b0, 1'b0, 3'd1, 16'd4);

    // Reset asserted mid-stream while stalled.
    ready_mode = 2;
    ext_trig = 1'b1;
    tick(3);
    ext_trig = 1'b0;
    wait_state(3'd2, 20);
    capture_frame(1, 1'b1, 4, 1'b0);
    k = 0;
    while (!src_valid && k < 100) begin
      tick(1);
      k++;
    end
    check("valid_seen", {31'd0, src_valid}, 32'd1);
    tick(3);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_state", {29'd0, state_o}, 32'd0);
    check("mid_rst_valid", {31'd0, src_valid}, 32'd0);
    check("mid_rst_cnt", {16'd0, frame_cnt}, 32'd0);
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("post_rst_state", {29'd0, state_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
